// File: rtl/range_scan_regfile.sv
// Register file over an ascending, descending or single-element index range,
// with registered random read/write and a valid/ready scan engine.
module range_scan_regfile #(
    parameter int WIDTH = 8,
    parameter int AFROM = 0,
    parameter int ATO   = 7,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             addr_err,
    input  logic             scan_start,
    input  logic             scan_ready,
    output logic             scan_valid,
    output logic [AW-1:0]    scan_index,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_busy,
    output logic             scan_done
);

    localparam int LO    = (AFROM < ATO) ? AFROM : ATO;
    localparam int HI    = (AFROM < ATO) ? ATO : AFROM;
    localparam int DEPTH = HI - LO + 1;
    localparam bit ASC   = (ATO > AFROM);

    localparam logic [AW-1:0] LO_A   = AW'(LO);
    localparam logic [AW-1:0] LAST_O = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FROM_A = AW'(AFROM);
    localparam logic [AW-1:0] TO_A   = AW'(ATO);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             addr_err_q, addr_err_d;

    logic [AW-1:0]    wr_off, rd_off, scan_off;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] rd_word, scan_word;

    // Offsets below LO wrap to large values, so one compare covers both bounds.
    assign wr_off   = wr_addr - LO_A;
    assign rd_off   = rd_addr - LO_A;
    assign scan_off = idx_q - LO_A;
    assign wr_ok    = (wr_off <= LAST_O);
    assign rd_ok    = (rd_off <= LAST_O);

    always_comb begin
        mem_d     = mem_q;
        rd_word   = '0;
        scan_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && wr_ok && (wr_off == AW'(i))) mem_d[i] = wr_data;
            if (rd_off == AW'(i))   rd_word   = mem_q[i];
            if (scan_off == AW'(i)) scan_word = mem_q[i];
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        addr_err_d = (rd_en && !rd_ok) || (wr_en && !wr_ok);
        if (rd_en) rd_data_d = rd_ok ? rd_word : '0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = SCAN;
                    idx_d   = FROM_A;
                end
            end
            SCAN: begin
                if (scan_ready) begin
                    if (idx_q == TO_A) state_d = DONE;
                    else if (ASC)      idx_d = idx_q + AW'(1);
                    else               idx_d = idx_q - AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = FROM_A;
            end
            default: begin
                state_d = IDLE;
                idx_d   = FROM_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            idx_q      <= FROM_A;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            mem_q      <= mem_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign addr_err   = addr_err_q;
    assign scan_valid = (state_q == SCAN);
    assign scan_busy  = (state_q == SCAN);
    assign scan_done  = (state_q == DONE);
    assign scan_index = idx_q;
    assign scan_data  = scan_valid ? scan_word : '0;

endmodule

// File: tb/tb_range_scan_regfile.sv
// Directed bench: ascending, descending and single-element instances
// share the random-access inputs and have separate scan controls.
module tb_range_scan_regfile;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr_en, rd_en;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;

    logic       a_start, a_ready, d_start, d_ready, s_start, s_ready;
    logic [7:0] a_rd_data, d_rd_data, s_rd_data;
    logic       a_rd_valid, d_rd_valid, s_rd_valid;
    logic       a_err, d_err, s_err;
    logic       a_valid, d_valid, s_valid;
    logic [3:0] a_index, d_index, s_index;
    logic [7:0] a_data, d_data, s_data;
    logic       a_busy, d_busy, s_busy;
    logic       a_done, d_done, s_done;

    int tests = 0;
    int fails = 0;
    logic [7:0] mdl [16];

    always #5 clk = ~clk;

    range_scan_regfile #(.WIDTH(8), .AFROM(0), .ATO(7), .AW(4)) u_asc (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .addr_err(a_err),
        .scan_start(a_start), .scan_ready(a_ready),
        .scan_valid(a_valid), .scan_index(a_index), .scan_data(a_data),
        .scan_busy(a_busy), .scan_done(a_done)
    );

    range_scan_regfile #(.WIDTH(8), .AFROM(7), .ATO(0), .AW(4)) u_dsc (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d_rd_data), .rd_valid(d_rd_valid), .addr_err(d_err),
        .scan_start(d_start), .scan_ready(d_ready),
        .scan_valid(d_valid), .scan_index(d_index), .scan_data(d_data),
        .scan_busy(d_busy), .scan_done(d_done)
    );

    range_scan_regfile #(.WIDTH(8), .AFROM(5), .ATO(5), .AW(4)) u_one (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .addr_err(s_err),
        .scan_start(s_start), .scan_ready(s_ready),
        .scan_valid(s_valid), .scan_index(s_index), .scan_data(s_data),
        .scan_busy(s_busy), .scan_done(s_done)
    );

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [3:0] ra;
        logic [7:0] ed;
        logic       ev;
        logic       ee;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [7:0] wd,
                                logic re, logic [3:0] ra,
                                logic [7:0] ed, logic ev, logic ee);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.ed = ed; v.ev = ev; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0: a_start = v;
            1: d_start = v;
            default: s_start = v;
        endcase
    endtask

    task automatic set_ready(input int w, input logic v);
        case (w)
            0: a_ready = v;
            1: d_ready = v;
            default: s_ready = v;
        endcase
    endtask

    task automatic get_scan(input int w, output logic v, output logic [3:0] idx,
                            output logic [7:0] dat, output logic dn);
        case (w)
            0: begin v = a_valid; idx = a_index; dat = a_data; dn = a_done; end
            1: begin v = d_valid; idx = d_index; dat = d_data; dn = d_done; end
            default: begin
                v = s_valid; idx = s_index; dat = s_data; dn = s_done;
            end
        endcase
    endtask

    task automatic run_scan(input int w, input int first, input int dir,
                            input int n, input bit stall);
        int   beats = 0;
        int   cyc   = 0;
        int   ei;
        bit   acc_prev = 0;
        bit   done_seen = 0;
        logic v, dn, rdy;
        logic [3:0] idx;
        logic [7:0] dat;
        set_ready(w, 1'b1);
        set_start(w, 1'b1);
        step();
        set_start(w, 1'b0);
        while (!done_seen && cyc < 100) begin
            get_scan(w, v, idx, dat, dn);
            if (dn) begin
                done_seen = 1;
                chk("scan_beats", 32'(beats), 32'(n));
                chk("done_after_last", 32'(acc_prev), 32'd1);
                chk("done_valid_low", 32'(v), 32'd0);
            end else begin
                ei = first + dir * beats;
                chk("scan_valid", 32'(v), 32'd1);
                chk("scan_index", 32'(idx), 32'(ei[3:0]));
                chk("scan_data", 32'(dat), 32'(mdl[ei[3:0]]));
                rdy = stall ? logic'(cyc % 3 != 1) : 1'b1;
                set_ready(w, rdy);
                acc_prev = v && rdy;
                if (acc_prev) beats++;
                step();
                cyc++;
            end
        end
        if (!done_seen) chk("scan_timeout", 32'd0, 32'd1);
        step();
        get_scan(w, v, idx, dat, dn);
        chk("done_one_cycle", 32'(dn), 32'd0);
        chk("idle_index", 32'(idx), 32'(first));
    endtask

    initial begin
        rstn = 1'b0;
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
        a_start = 0; a_ready = 0; d_start = 0; d_ready = 0;
        s_start = 0; s_ready = 0;

        for (int i = 0; i < 8; i++) vt.push_back(mk(0, 0, 0, 1, 4'(i), 8'h00, 1, 0));
        for (int i = 0; i < 8; i++) vt.push_back(mk(1, 4'(i), 8'(8'h10 + i), 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 4'd3, 8'h13, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 4'd0, 8'h13, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 4'd9, 8'h00, 1, 1));
        vt.push_back(mk(1, 4'd8, 8'hEE, 0, 4'd0, 8'h00, 0, 1));
        vt.push_back(mk(1, 4'd2, 8'h55, 1, 4'd2, 8'h12, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 4'd2, 8'h55, 1, 0));
        vt.push_back(mk(1, 4'd2, 8'h12, 0, 4'd0, 8'h55, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 4'd15, 8'h00, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0));

        step();
        chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_scan_valid", 32'(a_valid), 32'd0);
        chk("rst_asc_index", 32'(a_index), 32'd0);
        chk("rst_dsc_index", 32'(d_index), 32'd7);
        chk("rst_one_index", 32'(s_index), 32'd5);
        rstn = 1'b1;

        foreach (vt[k]) begin
            wr_en = vt[k].we; wr_addr = vt[k].wa; wr_data = vt[k].wd;
            rd_en = vt[k].re; rd_addr = vt[k].ra;
            step();
            chk($sformatf("vec%0d_rd_data", k), 32'(a_rd_data), 32'(vt[k].ed));
            chk($sformatf("vec%0d_rd_valid", k), 32'(a_rd_valid), 32'(vt[k].ev));
            chk($sformatf("vec%0d_addr_err", k), 32'(a_err), 32'(vt[k].ee));
        end
        wr_en = 0; rd_en = 0;

        for (int i = 0; i < 16; i++) mdl[i] = 8'(8'h10 + i);
        run_scan(0, 0, 1, 8, 0);
        run_scan(1, 7, -1, 8, 1);

        wr_en = 1; wr_addr = 4'd5; wr_data = 8'hA5;
        step();
        chk("one_wr_ok_err", 32'(s_err), 32'd0);
        wr_addr = 4'd4; wr_data = 8'h44;
        step();
        chk("one_wr_bad_err", 32'(s_err), 32'd1);
        wr_en = 0; rd_en = 1; rd_addr = 4'd5;
        step();
        rd_en = 0;
        chk("one_err_pulse", 32'(s_err), 32'd0);
        chk("one_rd_data", 32'(s_rd_data), 32'hA5);
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl[5] = 8'hA5;
        run_scan(2, 5, 0, 1, 0);

        a_ready = 1; a_start = 1;
        step();
        a_start = 0;
        for (int i = 0; i < 10 && a_index != 4'd3; i++) step();
        a_ready = 0;
        chk("cc_at3_index", 32'(a_index), 32'd3);
        chk("cc_at3_data", 32'(a_data), 32'h13);
        wr_en = 1; wr_addr = 4'd3; wr_data = 8'h99; a_start = 1;
        step();
        wr_en = 0; a_start = 0;
        chk("cc_stall_index", 32'(a_index), 32'd3);
        chk("cc_live_data", 32'(a_data), 32'h99);
        chk("cc_busy", 32'(a_busy), 32'd1);
        wr_en = 1; wr_addr = 4'd2; wr_data = 8'h77; rd_en = 1; rd_addr = 4'd2;
        step();
        wr_en = 0; rd_en = 0;
        chk("cc_rbw_data", 32'(a_rd_data), 32'h12);
        chk("cc_rbw_valid", 32'(a_rd_valid), 32'd1);
        a_ready = 1;
        step();
        a_ready = 0;
        chk("cc_at4_index", 32'(a_index), 32'd4);
        chk("cc_at4_data", 32'(a_data), 32'h44);
        rd_en = 1; rd_addr = 4'd2;
        step();
        rd_en = 0;
        chk("cc_new_data", 32'(a_rd_data), 32'h77);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("mid_rst_rd_data", 32'(a_rd_data), 32'd0);
        chk("mid_rst_valid", 32'(a_valid), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_index", 32'(a_index), 32'd0);
        step();
        rstn = 1'b1;
        rd_en = 1; rd_addr = 4'd3;
        step();
        rd_en = 0;
        chk("post_rst_entry", 32'(a_rd_data), 32'd0);
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        run_scan(0, 0, 1, 8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/range_scan_regfile.md
Name: range_scan_regfile

Overview:
Parametrised register file whose index range is given as FROM/TO bounds in either direction: ascending, descending, or single element. It supports random write and registered read by index, plus a sequential scan engine. The scan engine streams every entry in declaration order, from FROM to TO, over a valid/ready handshake. It is used as a configuration and readback store in TMR-protected designs, where both range directions must be handled.

Parameters:
WIDTH, 8, data bits per entry.
AFROM, 0, first index of the array range, in declaration order.
ATO, 7, last index of the array range; may be less than, equal to, or greater than AFROM.
AW, 4, index port width; must hold max(AFROM, ATO).

Ports:
clk  input  1  rising-edge clock.
rstn  input  1  asynchronous active-low reset.
wr_en  input  1  write strobe.
wr_addr  input  AW  write index.
wr_data  input  WIDTH  write data.
rd_en  input  1  read strobe.
rd_addr  input  AW  read index.
rd_data  output  WIDTH  registered read data.
rd_valid  output  1  rd_data valid, 1 cycle after rd_en.
addr_err  output  1  one-cycle pulse on an out-of-range rd_addr or wr_addr.
scan_start  input  1  start a full scan; ignored unless the FSM is IDLE.
scan_ready  input  1  consumer accepts the current scan beat.
scan_valid  output  1  a scan beat is presented.
scan_index  output  AW  index of the current beat.
scan_data  output  WIDTH  entry content of the current beat.
scan_busy  output  1  high in the SCAN state.
scan_done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- DEPTH = |ATO-AFROM|+1. An index is legal iff it lies between min(AFROM,ATO) and max(AFROM,ATO) inclusive.
- Reset (asynchronous, effective at any time, including mid-scan):
  - all entries = 0; rd_data = 0; rd_valid = 0; addr_err = 0.
  - scan_valid = 0, scan_busy = 0, scan_done = 0, scan_index = AFROM, scan_data = 0; FSM = IDLE.
- Write: on a clock edge with wr_en=1 and a legal wr_addr, the entry is updated. An illegal wr_addr leaves the array unchanged and sets addr_err=1 on the next cycle.
- Read: rd_en=1 → next cycle rd_valid=1 and rd_data = the entry's pre-edge content.
  - A write to the same index in the same cycle returns the old data (read-before-write).
  - An illegal rd_addr gives rd_data=0, rd_valid=1 and addr_err=1.
  - rd_data holds its value when rd_en=0; rd_valid=0.
- addr_err is the OR of the read-error and write-error conditions, registered, one cycle wide.
- Scan FSM has states IDLE, SCAN, DONE.
  - IDLE: on scan_start=1 → SCAN, with scan_index=AFROM and scan_valid=1 from the next cycle.
  - SCAN: scan_data is combinational from the array at scan_index, so a write that lands before acceptance is visible. A beat completes when scan_valid & scan_ready.
    - On completion with scan_index≠ATO, step scan_index by +1 if ATO>AFROM, else −1.
    - On completion with scan_index=ATO → DONE.
    - scan_ready=0 holds the index and stalls indefinitely.
  - DONE: scan_valid=0, scan_done=1 for exactly one cycle, then → IDLE with scan_index reset to AFROM. A scan_start during DONE is ignored.
- scan_start in SCAN or DONE is ignored; no restart.
- Random read/write proceeds concurrently with a scan without interference.
- Single-element range (AFROM=ATO): the scan emits exactly one beat, then DONE.
- Index stepping never wraps. It terminates only on a match with ATO; there is no arithmetic wrap at the AW limits.

Test Plan:
- Reset, then read all 8 indices (defaults) → rd_data=0, rd_valid=1 each, addr_err=0. Assert rstn mid-read → rd_valid drops to 0 immediately.
- Ascending (AFROM=0, ATO=7): write entry i=0x10+i, scan with scan_ready=1 → 8 beats, index 0..7, data 0x10..0x17, scan_done 1 cycle after beat 7.
- Descending (AFROM=7, ATO=0): same fill → beats ordered 7..0, data 0x17..0x10. Toggle scan_ready 1-0-1 → index holds during the stall, no beat lost or duplicated.
- Single element (AFROM=ATO=5): write 0xA5 at 5 → one beat, index 5, data 0xA5, then scan_done. Write at 4 → addr_err pulse, array unchanged.
- Concurrency: during a scan stalled at index 3, write 0x99 to 3 → beat 3 shows 0x99. A scan_start during the scan is ignored. Same-cycle rd/wr to 2 → old data returned.
- Reset mid-scan at index 4 → scan_valid=0, scan_busy=0, all entries 0. The next scan_start restarts at AFROM.
